dla_vram_arbiter: RTL and testbench
===================================

# dla_vram_arbiter

Avalon-MM slave that serves VRAM requests from the DLA engine, which includes the particle checker and the particle writer. It shares a single-port synchronous RAM with the VGA scan-out read port, which has priority. One RAM access is issued per cycle. Read data returns in issue order with fixed latency, and a starvation guard bounds how long the Avalon side can be stalled.

## Interface
Parameters:
- AVN_AW, 19, Avalon and RAM word-address width
- AVN_DW, 16, data width
- RAM_LAT, 2, RAM read latency in cycles from ram_addr to ram_rdata; legal range 1..4
- STARVE_MAX, 15, maximum consecutive stalled cycles for a pending Avalon request; legal range 1..255

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- avn_address  in  AVN_AW  Avalon word address
- avn_read  in  1  read request
- avn_write  in  1  write request
- avn_writedata  in  AVN_DW  write data
- avn_waitrequest  out  1  stall; the request is accepted when it is low
- avn_readdata  out  AVN_DW  read data
- avn_readdatavalid  out  1  read data valid
- disp_req  in  1  scan-out read request
- disp_addr  in  AVN_AW  scan-out address
- disp_gnt  out  1  scan-out request issued this cycle
- disp_rdata  out  AVN_DW  scan-out read data
- disp_rvalid  out  1  scan-out data valid
- ram_addr  out  AVN_AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  AVN_DW  RAM write data
- ram_rdata  in  AVN_DW  RAM read data

## Operation
Request signals:
- avn_req = avn_read | avn_write.
- Asserting avn_read and avn_write in the same cycle is illegal. If it happens, the access is treated as a write and no read response is produced.

Grant decision, made combinationally each cycle:
- Starved: avn_req is high and starve_cnt == STARVE_MAX. The Avalon side is granted.
- Otherwise, if disp_req is high, the display is granted (disp_gnt=1).
- Otherwise, if avn_req is high, the Avalon side is granted.
- avn_waitrequest = !ready | (avn_req & !avn_gnt).
- disp_gnt is 0 while ready is low.

Starvation counter (starve_cnt, 8 bits):
- Increments on each cycle with avn_req & !avn_gnt.
- Clears on an Avalon grant or when avn_req is low.
- Saturates at STARVE_MAX.

RAM port:
- ram_addr comes from the granted requester.
- ram_we = avn_gnt & avn_write.
- ram_wdata = avn_writedata.
- When nothing is granted, ram_addr holds its previous value and ram_we=0.

Read tag pipeline:
- RAM_LAT stages, each holding {valid, owner}, where owner is DISP or AVN.
- Stage 0 is loaded with valid = (display grant | Avalon read grant).
- At the last stage, ram_rdata is registered into disp_rdata or avn_readdata according to owner, and the matching rvalid pulses for one cycle.
- The data register of the other owner holds its previous value.

Ordering:
- Reads and writes hit the RAM in grant order.
- A read issued after a write to the same address returns the new data.

ready flop:
- Cleared by reset.
- Set on the first clk edge after rst_n deasserts.

## Timing
- Read latency for both ports: RAM_LAT+1 cycles from the grant cycle to the valid pulse.
- Writes complete in the grant cycle and produce no response.
- Throughput: one access per cycle, up to RAM_LAT reads in flight. readdatavalid cannot be back-pressured, so no buffering is needed.
- Reset values:
  - avn_waitrequest=1 during reset and through the first cycle after release.
  - avn_readdatavalid=0, disp_rvalid=0, disp_gnt=0.
  - avn_readdata=0, disp_rdata=0.
  - ram_we=0, ram_addr=0.
  - starve_cnt=0; all tag stages invalid.
- Reset mid-operation: all in-flight tags are dropped, no valid pulses occur afterwards, and a write in progress is not guaranteed.
- Simultaneous disp_req and avn_req with starve_cnt < STARVE_MAX: the display wins.

## Structure
- Package dla_pkg holds typedef enum logic {OWN_DISP, OWN_AVN} owner_t and typedef struct packed {logic valid; owner_t owner;} rd_tag_t.
- The tag pipeline is one natural sub-module, dla_tag_pipe, parameterized by depth RAM_LAT.
- The arbiter and starvation counter live in the top level.

## Test plan
- Idle display; Avalon write 0x1234 to address 100, then read address 100: waitrequest stays low, and readdatavalid rises 3 cycles after the read grant (RAM_LAT=2) with readdata=0x1234.
- disp_req held high for 40 cycles with an Avalon read pending: exactly one Avalon grant after 15 stalled cycles (cycle 16), and disp_gnt=0 in that cycle. Repeats every 16 cycles.
- Interleaved display and Avalon reads on alternating cycles with distinct RAM contents: each data word is routed to the correct port, in order, with no cross-delivery.
- Reset asserted with 2 reads in flight: no rvalid pulses after reset; waitrequest=1 until one cycle after rst_n rises; then a read succeeds normally.
- avn_read and avn_write asserted together at address 5 with data 0xBEEF: RAM written with 0xBEEF, no readdatavalid produced.
- RAM_LAT=4, four back-to-back Avalon reads: four consecutive readdatavalid pulses, starting 5 cycles after the first grant.

Source files
------------

// File: rtl/dla_pkg.sv
// Shared types for the DLA VRAM arbiter: read-tag owner and the tag carried alongside each RAM read.
package dla_pkg;
    typedef enum logic {OWN_DISP, OWN_AVN} owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

    localparam int STARVE_W = 8;
endpackage

// File: rtl/dla_tag_pipe.sv
// Delay line of read tags matching the RAM read latency; tag_o lines up with ram_rdata.
// DEPTH-cycle latency, no backpressure (one tag in and one out every cycle).
module dla_tag_pipe import dla_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);
    rd_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '{valid: 1'b0, owner: OWN_DISP};
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];
endmodule

// File: rtl/dla_vram_arbiter.sv
// Single-port VRAM arbiter: scan-out has priority, Avalon side gets a forced slot after STARVE_MAX stalls.
// Reads return RAM_LAT+1 cycles after grant, in order; read data is never back-pressured.
module dla_vram_arbiter import dla_pkg::*; #(
    parameter int AVN_AW     = 19,
    parameter int AVN_DW     = 16,
    parameter int RAM_LAT    = 2,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AVN_AW-1:0] avn_address,
    input  logic              avn_read,
    input  logic              avn_write,
    input  logic [AVN_DW-1:0] avn_writedata,
    output logic              avn_waitrequest,
    output logic [AVN_DW-1:0] avn_readdata,
    output logic              avn_readdatavalid,
    input  logic              disp_req,
    input  logic [AVN_AW-1:0] disp_addr,
    output logic              disp_gnt,
    output logic [AVN_DW-1:0] disp_rdata,
    output logic              disp_rvalid,
    output logic [AVN_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [AVN_DW-1:0] ram_wdata,
    input  logic [AVN_DW-1:0] ram_rdata
);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic                ready_q;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [AVN_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [AVN_DW-1:0]   avn_rdata_q, disp_rdata_q;
    logic                avn_rvalid_q, disp_rvalid_q;
    logic                avn_req, starved, avn_gnt, disp_gnt_c;
    rd_tag_t             tag_in, tag_out;

    assign avn_req = avn_read | avn_write;
    assign starved = avn_req && (starve_cnt_q == STARVE_LIM);

    always_comb begin
        avn_gnt      = 1'b0;
        disp_gnt_c   = 1'b0;
        starve_cnt_d = starve_cnt_q;
        ram_addr_d   = ram_addr_q;
        if (ready_q) begin
            if (starved) begin
                avn_gnt = 1'b1;
            end else if (disp_req) begin
                disp_gnt_c = 1'b1;
            end else if (avn_req) begin
                avn_gnt = 1'b1;
            end
        end
        if (!avn_req || avn_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
        if (disp_gnt_c) begin
            ram_addr_d = disp_addr;
        end else if (avn_gnt) begin
            ram_addr_d = avn_address;
        end
    end

    // A simultaneous read+write is a write: it must not launch a read tag.
    always_comb begin
        tag_in       = '{valid: 1'b0, owner: OWN_DISP};
        tag_in.valid = disp_gnt_c | (avn_gnt & avn_read & ~avn_write);
        tag_in.owner = disp_gnt_c ? OWN_DISP : OWN_AVN;
    end

    dla_tag_pipe #(.DEPTH(RAM_LAT)) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q       <= 1'b0;
            starve_cnt_q  <= '0;
            ram_addr_q    <= '0;
            avn_rvalid_q  <= 1'b0;
            disp_rvalid_q <= 1'b0;
            avn_rdata_q   <= '0;
            disp_rdata_q  <= '0;
        end else begin
            ready_q       <= 1'b1;
            starve_cnt_q  <= starve_cnt_d;
            ram_addr_q    <= ram_addr_d;
            avn_rvalid_q  <= tag_out.valid && (tag_out.owner == OWN_AVN);
            disp_rvalid_q <= tag_out.valid && (tag_out.owner == OWN_DISP);
            if (tag_out.valid && (tag_out.owner == OWN_AVN)) begin
                avn_rdata_q <= ram_rdata;
            end
            if (tag_out.valid && (tag_out.owner == OWN_DISP)) begin
                disp_rdata_q <= ram_rdata;
            end
        end
    end

    assign avn_waitrequest   = !ready_q | (avn_req & !avn_gnt);
    assign avn_readdata      = avn_rdata_q;
    assign avn_readdatavalid = avn_rvalid_q;
    assign disp_gnt          = disp_gnt_c;
    assign disp_rdata        = disp_rdata_q;
    assign disp_rvalid       = disp_rvalid_q;
    assign ram_addr          = ram_addr_d;
    assign ram_we            = avn_gnt & avn_write;
    assign ram_wdata         = avn_writedata;
endmodule

// File: tb/tb_dla_vram_arbiter.sv
// Bench for dla_vram_arbiter: RAM_LAT=2 instance with a scoreboard, plus a RAM_LAT=4 instance.
module tb_dla_vram_arbiter;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] avn_address = '0, disp_addr = '0, ram_addr;
    logic avn_read = 1'b0, avn_write = 1'b0, disp_req = 1'b0;
    logic [DW-1:0] avn_writedata = '0, avn_readdata, disp_rdata, ram_wdata, ram_rdata;
    logic avn_waitrequest, avn_readdatavalid, disp_gnt, disp_rvalid, ram_we;

    logic [AW-1:0] b_address = '0, b_disp_addr = '0, b_ram_addr;
    logic b_read = 1'b0, b_write = 1'b0, b_disp_req = 1'b0;
    logic [DW-1:0] b_wdata = '0, b_rdata, b_disp_rdata, b_ram_wdata, b_ram_rdata;
    logic b_wait, b_rvalid, b_disp_gnt, b_disp_rvalid, b_ram_we;

    dla_vram_arbiter #(.AVN_AW(AW), .AVN_DW(DW), .RAM_LAT(LAT), .STARVE_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .avn_address(avn_address), .avn_read(avn_read), .avn_write(avn_write),
        .avn_writedata(avn_writedata), .avn_waitrequest(avn_waitrequest),
        .avn_readdata(avn_readdata), .avn_readdatavalid(avn_readdatavalid),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    dla_vram_arbiter #(.AVN_AW(AW), .AVN_DW(DW), .RAM_LAT(4), .STARVE_MAX(15)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .avn_address(b_address), .avn_read(b_read), .avn_write(b_write),
        .avn_writedata(b_wdata), .avn_waitrequest(b_wait),
        .avn_readdata(b_rdata), .avn_readdatavalid(b_rvalid),
        .disp_req(b_disp_req), .disp_addr(b_disp_addr), .disp_gnt(b_disp_gnt),
        .disp_rdata(b_disp_rdata), .disp_rvalid(b_disp_rvalid),
        .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    // Default RAM contents: distinct per address so misrouted data is visible.
    function automatic logic [DW-1:0] init_val(input logic [7:0] a);
        return 16'hC000 ^ {a, ~a};
    endfunction

    // Behavioural synchronous RAM (256 words, low address bits), one read pipe per instance.
    logic [DW-1:0] mem [256];
    bit            mem_w [256];
    logic [DW-1:0] pipe2 [2];
    logic [DW-1:0] pipe4 [4];

    function automatic logic [DW-1:0] ram_rd(input logic [7:0] a);
        return mem_w[a] ? mem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[7:0]]   <= ram_wdata;
            mem_w[ram_addr[7:0]] <= 1'b1;
        end
        pipe2[0] <= ram_rd(ram_addr[7:0]);
        pipe2[1] <= pipe2[0];
        pipe4[0] <= ram_rd(b_ram_addr[7:0]);
        for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
    end
    assign ram_rdata   = pipe2[1];
    assign b_ram_rdata = pipe4[3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int failed = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t avn_q[$];
    exp_t disp_q[$];

    logic [DW-1:0] shadow [256];
    bit            sh_w [256];

    function automatic logic [DW-1:0] model_rd(input logic [7:0] a);
        return sh_w[a] ? shadow[a] : init_val(a);
    endfunction

    task automatic scoreboard_mon();
        exp_t e;
        forever begin
            @(negedge clk);
            if (disp_gnt) begin
                e.data = model_rd(disp_addr[7:0]);
                e.due  = cyc + LAT + 1;
                disp_q.push_back(e);
            end
            if ((avn_read || avn_write) && !avn_waitrequest) begin
                if (avn_write) begin
                    shadow[avn_address[7:0]] = avn_writedata;
                    sh_w[avn_address[7:0]]   = 1'b1;
                end else begin
                    e.data = model_rd(avn_address[7:0]);
                    e.due  = cyc + LAT + 1;
                    avn_q.push_back(e);
                end
            end
            if (disp_rvalid) begin
                tests_run++;
                if (disp_q.size() == 0) begin
                    failed++;
                    $display("FAIL disp_unexpected_rvalid data=%h cyc=%0d expected no pulse", disp_rdata, cyc);
                end else begin
                    e = disp_q.pop_front();
                    if (disp_rdata !== e.data || cyc !== e.due) begin
                        failed++;
                        $display("FAIL disp_read got %h at cyc %0d, expected %h at cyc %0d", disp_rdata, cyc, e.data, e.due);
                    end
                end
            end
            if (avn_readdatavalid) begin
                tests_run++;
                if (avn_q.size() == 0) begin
                    failed++;
                    $display("FAIL avn_unexpected_rvalid data=%h cyc=%0d expected no pulse", avn_readdata, cyc);
                end else begin
                    e = avn_q.pop_front();
                    if (avn_readdata !== e.data || cyc !== e.due) begin
                        failed++;
                        $display("FAIL avn_read got %h at cyc %0d, expected %h at cyc %0d", avn_readdata, cyc, e.data, e.due);
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic avn_idle();
        avn_read  = 1'b0;
        avn_write = 1'b0;
    endtask

    // Holds the request until accepted; returns just after the accepting edge.
    task automatic avn_issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output int stalls);
        avn_read = rd; avn_write = wr; avn_address = a; avn_writedata = d;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!avn_waitrequest) break;
            stalls++;
            if (stalls > 100) begin
                tests_run++; failed++;
                $display("FAIL avn_issue_timeout stalls=%0d limit=100", stalls);
                break;
            end
        end
        step();
    endtask

    task automatic drain();
        int n = 0;
        while ((avn_q.size() != 0 || disp_q.size() != 0) && n < 50) begin
            step();
            n++;
        end
        tests_run++;
        if (avn_q.size() != 0 || disp_q.size() != 0) begin
            failed++;
            $display("FAIL drain pending avn=%0d disp=%0d, expected 0 and 0", avn_q.size(), disp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; disp_req = 1'b1; disp_addr = 9; avn_read = 1'b1; avn_address = 3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({avn_waitrequest, avn_readdatavalid, disp_rvalid, disp_gnt, ram_we} !== 5'b10000) begin
            failed++;
            $display("FAIL reset_ctrl {wait,rdv,drv,dgnt,we}=%b expected 10000",
                     {avn_waitrequest, avn_readdatavalid, disp_rvalid, disp_gnt, ram_we});
        end
        tests_run++;
        if (avn_readdata !== 16'h0 || disp_rdata !== 16'h0) begin
            failed++;
            $display("FAIL reset_data avn=%h disp=%h expected 0000 0000", avn_readdata, disp_rdata);
        end
        tests_run++;
        if (ram_addr !== '0) begin
            failed++;
            $display("FAIL reset_ram_addr got %h expected 0", ram_addr);
        end
        step();
        disp_req = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (avn_waitrequest !== 1'b1) begin
            failed++;
            $display("FAIL wait_first_cycle got %b expected 1", avn_waitrequest);
        end
        @(negedge clk);
        tests_run++;
        if (avn_waitrequest !== 1'b0) begin
            failed++;
            $display("FAIL wait_second_cycle got %b expected 0", avn_waitrequest);
        end
        step();
        avn_idle();
        drain();
    endtask

    task automatic test_write_read();
        int s;
        avn_issue(1'b0, 1'b1, 100, 16'h1234, s);
        tests_run++;
        if (s != 0) begin failed++; $display("FAIL write_stall got %0d expected 0", s); end
        avn_issue(1'b1, 1'b0, 100, 16'h0, s);
        tests_run++;
        if (s != 0) begin failed++; $display("FAIL read_stall got %0d expected 0", s); end
        avn_idle();
        drain();
    endtask

    task automatic test_interleave();
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                avn_idle(); disp_req = 1'b1; disp_addr = AW'(10 + i);
            end else begin
                disp_req = 1'b0; avn_read = 1'b1; avn_address = AW'(50 + i);
            end
            @(negedge clk);
            tests_run++;
            if ((i % 2 == 0) ? (disp_gnt !== 1'b1) : (avn_waitrequest !== 1'b0)) begin
                failed++;
                $display("FAIL interleave_grant slot=%0d dgnt=%b wait=%b", i, disp_gnt, avn_waitrequest);
            end
            step();
        end
        disp_req = 1'b0; avn_idle();
        drain();
    endtask

    task automatic test_starvation();
        logic exp_g;
        disp_req = 1'b1; avn_read = 1'b1; avn_address = 7;
        for (int i = 1; i <= 40; i++) begin
            disp_addr = AW'(150 + i);
            exp_g = (i % 16 == 0);
            @(negedge clk);
            tests_run++;
            if (!avn_waitrequest !== exp_g || disp_gnt !== !exp_g) begin
                failed++;
                $display("FAIL starve_cycle %0d avn_gnt=%b dgnt=%b expected %b %b",
                         i, !avn_waitrequest, disp_gnt, exp_g, !exp_g);
            end
            step();
        end
        disp_req = 1'b0; avn_idle();
        drain();
    endtask

    task automatic test_rw_both();
        int s;
        int pulses = 0;
        avn_issue(1'b1, 1'b1, 5, 16'hBEEF, s);
        avn_idle();
        repeat (8) begin
            @(negedge clk);
            if (avn_readdatavalid) pulses++;
        end
        step();
        tests_run++;
        if (pulses != 0) begin failed++; $display("FAIL rw_both_rvalid got %0d pulses expected 0", pulses); end
        tests_run++;
        if (ram_rd(8'd5) !== 16'hBEEF) begin
            failed++;
            $display("FAIL rw_both_ram got %h expected beef", ram_rd(8'd5));
        end
        drain();
    endtask

    task automatic test_lat4();
        int  g0 = 0;
        logic exp_v;
        b_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b_address = AW'(60 + k);
            @(negedge clk);
            if (k == 0) g0 = cyc;
            tests_run++;
            if (b_wait !== 1'b0) begin failed++; $display("FAIL lat4_grant read %0d wait=%b expected 0", k, b_wait); end
            step();
        end
        b_read = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            exp_v = (cyc >= g0 + 5) && (cyc <= g0 + 8);
            tests_run++;
            if (b_rvalid !== exp_v || (exp_v && b_rdata !== init_val(8'(60 + cyc - g0 - 5)))) begin
                failed++;
                $display("FAIL lat4_resp cyc+%0d valid=%b data=%h expected valid=%b data=%h",
                         cyc - g0, b_rvalid, b_rdata, exp_v, init_val(8'(60 + cyc - g0 - 5)));
            end
        end
        step();
    endtask

    task automatic test_reset_inflight();
        int s;
        int pulses = 0;
        avn_issue(1'b1, 1'b0, 20, 16'h0, s);
        avn_issue(1'b1, 1'b0, 21, 16'h0, s);
        avn_idle();
        rst_n = 1'b0;
        avn_q.delete();
        disp_q.delete();
        repeat (6) begin
            @(negedge clk);
            if (avn_readdatavalid || disp_rvalid) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin failed++; $display("FAIL inflight_dropped got %0d pulses expected 0", pulses); end
        avn_read = 1'b1; avn_address = 22;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (avn_waitrequest !== 1'b1) begin failed++; $display("FAIL rerelease_wait got %b expected 1", avn_waitrequest); end
        step();
        avn_issue(1'b1, 1'b0, 22, 16'h0, s);
        tests_run++;
        if (s != 0) begin failed++; $display("FAIL post_reset_stall got %0d expected 0", s); end
        avn_idle();
        drain();
    endtask

    initial begin
        fork
            scoreboard_mon();
        join_none
        test_reset();
        test_write_read();
        test_interleave();
        test_starvation();
        test_rw_both();
        test_lat4();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
